tt_um_q3_sink_fifo: RTL and testbench
=====================================

TT_UM_Q3_SINK_FIFO -- requirements
Module: tt_um_q3_sink_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of FIFO entries; the only supported value is 4.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 ui_in  input  8  SHALL carry the upstream C word: bit 7 is the word-valid marker and bits 6:0 are the payload.
REQ-005 uio_in  input  8  SHALL carry controls: bit 0 is the pop request (level, edge-detected) and bit 1 is flush; bits 7:2 are ignored.
REQ-006 uo_out  output  8  SHALL present the head word: bit 7 is head-valid (not empty) and bits 6:0 are the head payload.
REQ-007 uio_out  output  8  SHALL carry status: bit 2 full, bit 3 empty, bit 4 sticky overflow, bits 7:5 occupancy count (0-4), bits 1:0 driven 0.
REQ-008 uio_oe  output  8  SHALL be constant 8'b1111_1100, so bits 1:0 are inputs and bits 7:2 are outputs.

Function
REQ-009 Push SHALL occur on an edge where ui_in[7]=1 and (not full or pop accepted on the same edge); it writes ui_in[6:0] at the tail.
REQ-010 A word with ui_in[7]=1 arriving while full and with no accepted pop SHALL be dropped and SHALL set the overflow flag.
REQ-011 ui_in[7]=0 SHALL cause no push, whatever the payload.
REQ-012 Pop request SHALL be the rising edge of uio_in[0]: registered prev_pop=0 and current uio_in[0]=1; one pop per rising edge.
REQ-013 Holding uio_in[0] high SHALL produce exactly one pop.
REQ-014 A pop request while empty SHALL be ignored; a simultaneous push still occurs, with no fall-through on that edge.
REQ-015 Simultaneous push and accepted pop SHALL leave the count unchanged and advance both pointers, including when full.
REQ-016 Pointers SHALL be 2 bits and wrap 3->0; count SHALL be 3 bits, 0..4, and never exceed 4 or underflow.
REQ-017 Flush (uio_in[1]=1) SHALL have priority over push and pop: it zeros pointers, count and overflow on that edge, and drops any coincident push.
REQ-018 Overflow SHALL remain set until flush or reset.
REQ-019 uo_out and uio_out SHALL be combinational decodes of registered state only, reflecting the state after the latest edge; ui_in/uio_in SHALL have no combinational path to outputs.
REQ-020 When empty, uo_out SHALL be 8'h00; stale storage SHALL NOT be visible.
REQ-021 Write-to-visible latency SHALL be one cycle: a word pushed into an empty FIFO appears on uo_out after that edge.

Reset
REQ-022 With rst_n=0 at a clock edge, pointers, count, overflow and prev_pop SHALL clear to 0; storage contents need not be cleared.
REQ-023 After reset, uo_out SHALL be 8'h00 and uio_out SHALL be 8'b0000_1000 (empty only).
REQ-024 Reset asserted mid-operation SHALL discard all queued words, and a push or pop on the same edge SHALL be ignored.
REQ-025 uio_oe SHALL be 8'b1111_1100 regardless of reset.

Structure
REQ-026 Package q3_pkg SHALL hold DEPTH, pointer width 2, count width 3, status bit indices (FULL=2, EMPTY=3, OVF=4, CNT_LSB=5) and the UIO_OE constant.
REQ-027 Storage, pointers and count SHALL live in one sub-module, q3_sync_fifo (push, pop, flush, wdata, rdata, full, empty, count).
REQ-028 The top level SHALL contain only pop edge detection, push/pop qualification, the overflow flag and output packing.

Verification
REQ-029 Reset, then idle -> uo_out=00, uio_out=08, uio_oe=FC.
REQ-030 Push 0x81, 0x82, 0x83 on consecutive cycles (ui_in[7]=1) -> count=3, uo_out=0x81; three pop pulses -> uo_out 0x82, 0x83, then 0x00 with empty=1.
REQ-031 Push 5 words 0x90..0x94 with no pops -> count=4, full=1, overflow=1, head=0x90; 0x94 is lost; after draining, the order is 0x90..0x93.
REQ-032 Full, then push 0xA5 with a pop rising edge on the same cycle -> count stays 4, head advances, and 0xA5 is last out; overflow does not set.
REQ-033 Hold uio_in[0]=1 for 5 cycles with 3 entries -> exactly 1 pop; pop while empty plus push 0x85 -> count=1 and uo_out=0x85.
REQ-034 With 2 entries and overflow set, assert flush with a push -> empty, overflow=0, uo_out=00; assert rst_n=0 mid-stream -> uio_out=08 on the next cycle.

Source files
------------

// File: rtl/q3_pkg.sv
// Shared constants and helpers for the q3 sink FIFO: depth, widths,
// status bit positions and the fixed bidirectional-pin direction mask.
package q3_pkg;

    localparam int          DEPTH      = 4;
    localparam int          PTR_W      = 2;
    localparam int          CNT_W      = 3;
    localparam int          DATA_W     = 7;

    localparam int          ST_FULL    = 2;
    localparam int          ST_EMPTY   = 3;
    localparam int          ST_OVF     = 4;
    localparam int          ST_CNT_LSB = 5;

    // Bits 1:0 are pop/flush inputs, bits 7:2 carry status out.
    localparam logic [7:0]  UIO_OE     = 8'b1111_1100;

    // Build the uio_out status byte; bits 1:0 stay 0 since they are inputs.
    function automatic logic [7:0] pack_status(input logic [CNT_W-1:0] cnt,
                                               input logic             ovf,
                                               input logic             empty,
                                               input logic             full);
        logic [7:0] s;
        s                              = 8'h00;
        s[ST_FULL]                     = full;
        s[ST_EMPTY]                    = empty;
        s[ST_OVF]                      = ovf;
        s[ST_CNT_LSB +: CNT_W]         = cnt;
        return s;
    endfunction

endpackage

// File: rtl/q3_sync_fifo.sv
// Four-entry synchronous FIFO: storage, wrapping 2-bit pointers and a 3-bit
// occupancy count. Push/pop arrive already qualified by the caller, so a push
// here is never lost and a pop never underflows.
module q3_sync_fifo
    import q3_pkg::*;
#(
    parameter int DEPTH_P = DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH_P];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    // Storage needs no reset: empty masks whatever stale data it holds.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and count; flush clears exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH_P));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/tt_um_q3_sink_fifo.sv
// Sink-side 4-deep FIFO for a Tiny Tapeout tile. Qualifies push/pop, detects
// the pop rising edge, keeps the sticky overflow flag and packs the pins.
// Outputs decode registered state only; inputs never reach them directly.
module tt_um_q3_sink_fifo
    import q3_pkg::*;
#(
    parameter int DEPTH = q3_pkg::DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic              r_prev_pop;
    logic              r_ovf;
    logic              w_pop_req;
    logic              w_flush;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    assign w_unused  = &{1'b0, uio_in[7:2]};

    assign w_flush   = uio_in[1];
    assign w_pop_req = uio_in[0] & ~r_prev_pop;
    // Flush wins over everything; a pop on empty is simply dropped.
    assign w_pop     = w_pop_req & ~w_empty & ~w_flush;
    // A full FIFO still accepts a word when a pop frees a slot on the same edge.
    assign w_push    = ui_in[7] & (~w_full | w_pop) & ~w_flush;

    // Pop edge detector history; holding the line high yields one pop.
    always_ff @(posedge clk) begin
        if (!rst_n) r_prev_pop <= 1'b0;
        else        r_prev_pop <= uio_in[0];
    end

    // Sticky overflow: set on a dropped word, cleared only by flush or reset.
    always_ff @(posedge clk) begin
        if (!rst_n || w_flush)                 r_ovf <= 1'b0;
        else if (ui_in[7] && w_full && !w_pop) r_ovf <= 1'b1;
    end

    q3_sync_fifo #(.DEPTH_P(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (ui_in[6:0]),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign uo_out  = w_empty ? 8'h00 : {1'b1, w_rdata};
    assign uio_out = pack_status(w_count, r_ovf, w_empty, w_full);
    assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_tt_um_q3_sink_fifo.sv
// Bench for tt_um_q3_sink_fifo: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_tt_um_q3_sink_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] m_q[$];
    bit         m_ovf  = 1'b0;
    bit         m_prev = 1'b0;

    always #5 clk = ~clk;

    tt_um_q3_sink_fifo #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one rising edge.
    task automatic model_edge(input logic rn, input logic [7:0] ui, input logic [7:0] uio);
        bit pop_ok;
        bit pop_req;
        if (!rn) begin
            m_q.delete();
            m_ovf  = 0;
            m_prev = 0;
            return;
        end
        pop_req = uio[0] && !m_prev;
        m_prev  = uio[0];
        if (uio[1]) begin
            m_q.delete();
            m_ovf = 0;
            return;
        end
        pop_ok = pop_req && (m_q.size() > 0);
        if (ui[7] && m_q.size() == 4 && !pop_ok) m_ovf = 1;
        if (pop_ok) void'(m_q.pop_front());
        if (ui[7] && m_q.size() < 4) m_q.push_back(ui[6:0]);
    endtask

    function automatic logic [7:0] exp_uo();
        return (m_q.size() == 0) ? 8'h00 : {1'b1, m_q[0]};
    endfunction

    function automatic logic [7:0] exp_uio();
        logic [2:0] sz;
        sz = 3'(m_q.size());
        return {sz, m_ovf ? 1'b1 : 1'b0, sz == 3'd0, sz == 3'd4, 2'b00};
    endfunction

    // Drive one cycle, advance the model, then compare just after the edge.
    task automatic step(input logic rn, input logic [7:0] ui, input logic [7:0] uio);
        rst_n  = rn;
        ui_in  = ui;
        uio_in = uio;
        @(posedge clk);
        model_edge(rn, ui, uio);
        #1;
        chk("uo_out",  uo_out,  exp_uo());
        chk("uio_out", uio_out, exp_uio());
        chk("uio_oe",  uio_oe,  8'hFC);
    endtask

    task automatic pop_pulse();
        step(1, 8'h00, 8'h01);
        step(1, 8'h00, 8'h00);
    endtask

    initial begin
        // Reset and idle
        step(0, 8'h00, 8'h00);
        chk("oe_in_reset", uio_oe, 8'hFC);
        step(0, 8'h00, 8'h00);
        step(1, 8'h00, 8'h00);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h08);

        // Three pushes, then three pops
        step(1, 8'h81, 8'h00);
        chk("lat1_uo", uo_out, 8'h81);
        step(1, 8'h82, 8'h00);
        step(1, 8'h83, 8'h00);
        chk("p3_cnt", {5'd0, uio_out[7:5]}, 8'd3);
        chk("p3_head", uo_out, 8'h81);
        pop_pulse(); chk("pop1", uo_out, 8'h82);
        pop_pulse(); chk("pop2", uo_out, 8'h83);
        pop_pulse(); chk("pop3", uo_out, 8'h00);
        chk("pop3_st", uio_out, 8'h08);

        // Overfill: fifth word lost, overflow sticks
        for (int i = 0; i < 5; i++) step(1, 8'h90 + 8'(i), 8'h00);
        chk("ovf_st", uio_out, 8'h94);
        chk("ovf_head", uo_out, 8'h90);
        for (int i = 0; i < 4; i++) begin
            chk("drain_ord", uo_out, 8'h90 + 8'(i));
            pop_pulse();
        end
        chk("drain_st", uio_out, 8'h18);
        step(1, 8'h00, 8'h02);
        chk("flush_st", uio_out, 8'h08);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 8'h00);
        step(1, 8'hA5, 8'h01);
        chk("pp_full_st", uio_out, 8'h84);
        chk("pp_full_head", uo_out, 8'hA1);
        step(1, 8'h00, 8'h00);
        chk("pp_o1", uo_out, 8'hA1); pop_pulse();
        chk("pp_o2", uo_out, 8'hA2); pop_pulse();
        chk("pp_o3", uo_out, 8'hA3); pop_pulse();
        chk("pp_o4", uo_out, 8'hA5); pop_pulse();
        chk("pp_empty", uio_out, 8'h08);

        // Held pop gives one pop; pop on empty with push
        for (int i = 0; i < 3; i++) step(1, 8'hB0 + 8'(i), 8'h00);
        for (int i = 0; i < 5; i++) step(1, 8'h00, 8'h01);
        chk("hold_cnt", {5'd0, uio_out[7:5]}, 8'd2);
        chk("hold_head", uo_out, 8'hB1);
        step(1, 8'h00, 8'h00);
        pop_pulse(); pop_pulse();
        step(1, 8'h85, 8'h01);
        chk("pe_uo", uo_out, 8'h85);
        chk("pe_cnt", {5'd0, uio_out[7:5]}, 8'd1);
        step(1, 8'h00, 8'h02);

        // Flush with coincident push, then reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 8'h00);
        pop_pulse(); pop_pulse();
        chk("pre_flush", uio_out, 8'h50);
        step(1, 8'hC7, 8'h02);
        chk("flush_uo", uo_out, 8'h00);
        chk("flush_uio", uio_out, 8'h08);
        step(1, 8'hD1, 8'h00);
        step(1, 8'hD2, 8'h00);
        step(0, 8'hD3, 8'h01);
        chk("mid_rst_uio", uio_out, 8'h08);
        chk("mid_rst_uo", uo_out, 8'h00);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       rn;
            logic [7:0] ui;
            logic [7:0] uio;
            rn  = ($urandom_range(0, 99) != 0);
            ui  = 8'($urandom);
            uio = 8'($urandom) & 8'hFD;
            if ($urandom_range(0, 19) == 0) uio[1] = 1'b1;
            step(rn, ui, uio);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
